// File: rtl/uart_tx_arbiter.sv
// Shares one UART sender between a DMA byte channel and a CPU word FIFO.
// CPU words go out little-endian, one byte per transfer; DMA wins between words.
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dma_req,
  input  logic [7:0]       dma_byte,
  output logic             dma_ack,
  input  logic             cpu_wr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_full,
  output logic [CNT_W-1:0] fifo_count,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       sdata,
  output logic             idle
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [31:0]      head;
  logic             lock, lock_n;
  logic [1:0]       idx, idx_n;
  logic             cur_dma, cur_dma_n;
  logic             start_n, ack_n;
  logic [7:0]       sdata_n;
  logic             push, pop;
  logic [CNT_W-1:0] count_n;
  logic             idle_n;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  assign head = mem[rd_ptr];

  // The head word leaves the FIFO as its last byte is handed to the sender;
  // a push on that same cycle is allowed even when full.
  assign pop  = (state == START) && !cur_dma && (idx == 2'd3);
  assign push = cpu_wr && (!cpu_full || pop);

  always_comb begin
    count_n = fifo_count;
    case ({push, pop})
      2'b10:   count_n = fifo_count + CNT_W'(1);
      2'b01:   count_n = fifo_count - CNT_W'(1);
      default: count_n = fifo_count;
    endcase
  end

  always_comb begin
    state_n   = state;
    lock_n    = lock;
    idx_n     = idx;
    cur_dma_n = cur_dma;
    start_n   = 1'b0;
    ack_n     = 1'b0;
    sdata_n   = sdata;
    case (state)
      IDLE: begin
        if (lock) begin
          start_n   = 1'b1;
          sdata_n   = word_byte(head, idx);
          cur_dma_n = 1'b0;
          state_n   = START;
        end else if (dma_req) begin
          start_n   = 1'b1;
          ack_n     = 1'b1;
          sdata_n   = dma_byte;
          cur_dma_n = 1'b1;
          state_n   = START;
        end else if (fifo_count != '0) begin
          start_n   = 1'b1;
          sdata_n   = word_byte(head, 2'd0);
          cur_dma_n = 1'b0;
          lock_n    = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        state_n = WAIT_BUSY;
        if (!cur_dma) begin
          idx_n = idx + 2'd1;
          if (idx == 2'd3) begin
            lock_n = 1'b0;
          end
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign idle_n = (state_n == IDLE) && (count_n == '0) && !lock_n;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      lock       <= 1'b0;
      idx        <= 2'd0;
      cur_dma    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      cpu_full   <= 1'b0;
      tx_start   <= 1'b0;
      sdata      <= 8'd0;
      dma_ack    <= 1'b0;
      idle       <= 1'b1;
    end else begin
      state      <= state_n;
      lock       <= lock_n;
      idx        <= idx_n;
      cur_dma    <= cur_dma_n;
      tx_start   <= start_n;
      dma_ack    <= ack_n;
      sdata      <= sdata_n;
      fifo_count <= count_n;
      cpu_full   <= (count_n == CNT_W'(FIFO_DEPTH));
      idle       <= idle_n;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-cycle vector table, then sender-model
// sequences for word ordering, DMA wait, FIFO full, reset and push-on-pop.
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 10;

  logic        clock;
  logic        reset;
  logic        dma_req;
  logic [7:0]  dma_byte;
  logic        dma_ack;
  logic        cpu_wr;
  logic [31:0] cpu_wdata;
  logic        cpu_full;
  logic [4:0]  fifo_count;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        idle;

  logic        model_en;
  logic        hold_busy;
  logic        tbl_busy;
  int          busy_cnt;

  int n_chk;
  int n_fail;
  int cyc;
  int last_start;
  bit have_last;

  logic [8:0] cap[$];
  logic [8:0] exp_q[$];

  typedef struct {
    logic        rst_n;
    logic        dreq;
    logic [7:0]  dbyte;
    logic        wr;
    logic [31:0] wdata;
    logic        busy;
    logic        e_start;
    logic [7:0]  e_sdata;
    logic        e_ack;
    logic        e_full;
    logic [4:0]  e_cnt;
    logic        e_idle;
  } vec_t;

  vec_t vt[14];

  uart_tx_arbiter #(.FIFO_DEPTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .dma_req    (dma_req),
    .dma_byte   (dma_byte),
    .dma_ack    (dma_ack),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata),
    .cpu_full   (cpu_full),
    .fifo_count (fifo_count),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .sdata      (sdata),
    .idle       (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign tx_busy = model_en ? ((busy_cnt != 0) || hold_busy) : tbl_busy;

  // Sender model: busy for BUSY_LEN cycles starting one cycle after a start.
  always @(posedge clock) begin
    if (tx_start) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (dma_ack === 1'b1) chk("ack_has_start", 32'(tx_start), 32'd1);
    if (tx_start === 1'b1) begin
      if (have_last) chk("start_spacing_ge4", 32'((cyc - last_start) >= 4), 32'd1);
      cap.push_back({dma_ack, sdata});
      last_start = cyc;
      have_last  = 1'b1;
    end
  end

  function automatic vec_t mk(input logic r, input logic dq, input logic [7:0] db,
                              input logic w, input logic [31:0] wd, input logic b,
                              input logic es, input logic [7:0] esd, input logic ea,
                              input logic ef, input logic [4:0] ec, input logic ei);
    vec_t v;
    v.rst_n = r;  v.dreq = dq;  v.dbyte = db;  v.wr = w;  v.wdata = wd;  v.busy = b;
    v.e_start = es;  v.e_sdata = esd;  v.e_ack = ea;  v.e_full = ef;  v.e_cnt = ec;  v.e_idle = ei;
    return v;
  endfunction

  function automatic logic [31:0] word_of(input int base, input int k);
    int b;
    b = base + 4 * k;
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  task automatic push_word(input logic [31:0] w);
    cpu_wr    = 1'b1;
    cpu_wdata = w;
    @(negedge clock);
    cpu_wr    = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < max) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_reach_idle"}, 32'(idle), 32'd1);
  endtask

  task automatic wait_start(input string name, input logic [7:0] b, input int max);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < max && !hit; n++) begin
      @(negedge clock);
      hit = (tx_start === 1'b1) && (sdata === b);
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  task automatic check_cap(input string name);
    chk({name, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      chk($sformatf("%s_b%0d", name, i), 32'(cap[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;  n_fail = 0;  cyc = 0;  last_start = 0;  have_last = 1'b0;  busy_cnt = 0;
    model_en = 1'b0;  hold_busy = 1'b0;  tbl_busy = 1'b0;
    reset = 1'b0;  dma_req = 1'b0;  dma_byte = 8'h00;  cpu_wr = 1'b0;  cpu_wdata = 32'h0;

    //         rst dreq byte   wr data           busy | start sdata  ack full cnt idle
    vt[0]  = mk(0, 0, 8'h00, 0, 32'h0,         0,     0, 8'h00, 0, 0, 5'd0, 1);
    vt[1]  = mk(1, 1, 8'h99, 0, 32'h0,         0,     1, 8'h99, 1, 0, 5'd0, 0);
    vt[2]  = mk(1, 0, 8'h99, 0, 32'h0,         0,     0, 8'h99, 0, 0, 5'd0, 0);
    vt[3]  = mk(1, 0, 8'h00, 0, 32'h0,         1,     0, 8'h99, 0, 0, 5'd0, 0);
    vt[4]  = mk(1, 0, 8'h00, 1, 32'h44332211,  1,     0, 8'h99, 0, 0, 5'd1, 0);
    vt[5]  = mk(1, 0, 8'h00, 0, 32'h0,         0,     0, 8'h99, 0, 0, 5'd1, 0);
    vt[6]  = mk(1, 0, 8'h00, 0, 32'h0,         0,     1, 8'h11, 0, 0, 5'd1, 0);
    vt[7]  = mk(1, 0, 8'h00, 0, 32'h0,         0,     0, 8'h11, 0, 0, 5'd1, 0);
    vt[8]  = mk(1, 0, 8'h00, 0, 32'h0,         1,     0, 8'h11, 0, 0, 5'd1, 0);
    vt[9]  = mk(1, 1, 8'haa, 0, 32'h0,         0,     0, 8'h11, 0, 0, 5'd1, 0);
    vt[10] = mk(1, 1, 8'haa, 0, 32'h0,         0,     1, 8'h22, 0, 0, 5'd1, 0);
    vt[11] = mk(1, 1, 8'haa, 0, 32'h0,         0,     0, 8'h22, 0, 0, 5'd1, 0);
    vt[12] = mk(0, 0, 8'h00, 0, 32'h0,         0,     0, 8'h00, 0, 0, 5'd0, 1);
    vt[13] = mk(1, 0, 8'h00, 0, 32'h0,         0,     0, 8'h00, 0, 0, 5'd0, 1);

    @(negedge clock);
    for (int i = 0; i < 14; i++) begin
      reset = vt[i].rst_n;  dma_req = vt[i].dreq;  dma_byte = vt[i].dbyte;
      cpu_wr = vt[i].wr;  cpu_wdata = vt[i].wdata;  tbl_busy = vt[i].busy;
      @(negedge clock);
      chk($sformatf("v%0d_tx_start", i),   32'(tx_start),   32'(vt[i].e_start));
      chk($sformatf("v%0d_sdata", i),      32'(sdata),      32'(vt[i].e_sdata));
      chk($sformatf("v%0d_dma_ack", i),    32'(dma_ack),    32'(vt[i].e_ack));
      chk($sformatf("v%0d_cpu_full", i),   32'(cpu_full),   32'(vt[i].e_full));
      chk($sformatf("v%0d_fifo_count", i), 32'(fifo_count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_idle", i),       32'(idle),       32'(vt[i].e_idle));
    end
    cpu_wr = 1'b0;  dma_req = 1'b0;  tbl_busy = 1'b0;
    repeat (15) @(negedge clock);
    model_en = 1'b1;
    @(negedge clock);

    // Single word, little-endian order
    cap.delete();
    push_word(32'h44332211);
    wait_start("w1_last_byte_start", 8'h44, 200);
    @(negedge clock);
    chk("w1_count_after_pop", 32'(fifo_count), 32'd0);
    wait_idle("w1", 200);
    exp_q = '{9'h011, 9'h022, 9'h033, 9'h044};
    check_cap("w1");

    // DMA request arriving mid-word waits for the word to finish
    cap.delete();
    push_word(32'hDDCCBBAA);
    wait_start("w2_first_byte", 8'hAA, 200);
    dma_req = 1'b1;  dma_byte = 8'hAA;
    begin
      bit got;
      got = 1'b0;
      for (int n = 0; n < 300 && !got; n++) begin
        @(negedge clock);
        got = (dma_ack === 1'b1);
      end
      chk("w2_dma_ack_seen", 32'(got), 32'd1);
    end
    dma_req = 1'b0;
    wait_idle("w2", 200);
    exp_q = '{9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h1AA};
    check_cap("w2");

    // Fill the FIFO with the sender held busy; 17th push is dropped
    cap.delete();
    hold_busy = 1'b1;
    for (int k = 0; k < 16; k++) push_word(word_of(16, k));
    chk("full_after_16", 32'(cpu_full), 32'd1);
    chk("count_after_16", 32'(fifo_count), 32'd16);
    push_word(32'hDEADBEEF);
    chk("full_after_17", 32'(cpu_full), 32'd1);
    chk("count_after_17", 32'(fifo_count), 32'd16);
    hold_busy = 1'b0;
    wait_idle("full", 3000);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back({1'b0, 8'(16 + i)});
    check_cap("full");

    // Push while full on the cycle the head word's last byte starts
    cap.delete();
    hold_busy = 1'b1;
    for (int k = 0; k < 16; k++) push_word(word_of(128, k));
    chk("pp_full_before", 32'(cpu_full), 32'd1);
    hold_busy = 1'b0;
    wait_start("pp_fourth_byte", 8'h83, 500);
    push_word(32'h5A5B5C5D);
    chk("pp_count_stays_16", 32'(fifo_count), 32'd16);
    chk("pp_full_stays", 32'(cpu_full), 32'd1);
    wait_idle("pp", 3000);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back({1'b0, 8'(128 + i)});
    exp_q.push_back(9'h05D);  exp_q.push_back(9'h05C);
    exp_q.push_back(9'h05B);  exp_q.push_back(9'h05A);
    check_cap("pp");

    // Reset during byte 2 of a word with three words queued
    cap.delete();
    for (int k = 0; k < 3; k++) push_word(word_of(192, k));
    wait_start("rst_byte2_start", 8'hC2, 300);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_cpu_full", 32'(cpu_full), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    repeat (100) @(negedge clock);
    chk("rst_no_more_starts", 32'(cap.size()), 32'd3);
    chk("rst_still_idle", 32'(idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
